// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline stage register: default widths,
// control-bit positions and the per-slot operation encoding.
package pipe_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int CTRL_W_DEF = 10;
  localparam int SKID_DEF   = 1;

  localparam int IDX_BRANCH   = 0;
  localparam int IDX_MEMREAD  = 1;
  localparam int IDX_MEMTOREG = 2;
  localparam int IDX_MEMWRITE = 3;
  localparam int IDX_REGWRITE = 4;
  localparam int IDX_ALUSRC   = 5;
  localparam int IDX_ALUOP0   = 6;
  localparam int IDX_ALUOP1   = 7;
  localparam int IDX_JUMP     = 8;
  localparam int IDX_HALT     = 9;

  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_LOAD  = 2'd1,
    SLOT_CLEAR = 2'd2
  } slot_op_e;

  function automatic logic [1:0] entry_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag plus data and control payload.
// Clearing drops the valid bit and zeroes control so a dead entry has no side effects.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  slot_op_e          op,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else begin
      case (op)
        SLOT_LOAD: begin
          valid <= 1'b1;
          data  <= load_data;
          ctrl  <= load_ctrl;
        end
        SLOT_CLEAR: begin
          valid <= 1'b0;
          ctrl  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer,
// hazard stall and top-priority flush.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SKID   = SKID_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        count
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  slot_op_e          main_op;
  slot_op_e          skid_op;
  logic [DATA_W-1:0] main_src_data;
  logic [CTRL_W-1:0] main_src_ctrl;
  logic              in_xfer;
  logic              out_xfer;

  assign out_xfer = main_valid & out_ready & ~stall;
  assign in_xfer  = in_valid & in_ready;

  // The skid entry only fills while main is held, and always drains into main
  // first, which keeps FIFO order. Without a skid entry skid_valid is tied low.
  always_comb begin
    main_op       = SLOT_HOLD;
    skid_op       = SLOT_HOLD;
    main_src_data = in_data;
    main_src_ctrl = in_ctrl;
    if (flush) begin
      main_op = SLOT_CLEAR;
      skid_op = SLOT_CLEAR;
    end else if (out_xfer) begin
      if (skid_valid) begin
        main_op       = SLOT_LOAD;
        main_src_data = skid_data;
        main_src_ctrl = skid_ctrl;
        skid_op       = SLOT_CLEAR;
      end else if (in_xfer) begin
        main_op = SLOT_LOAD;
      end else begin
        main_op = SLOT_CLEAR;
      end
    end else if (in_xfer) begin
      if (main_valid) skid_op = SLOT_LOAD;
      else            main_op = SLOT_LOAD;
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk       (clk),
    .reset     (reset),
    .op        (main_op),
    .load_data (main_src_data),
    .load_ctrl (main_src_ctrl),
    .valid     (main_valid),
    .data      (main_data),
    .ctrl      (main_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic ready_q;

      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .op        (skid_op),
        .load_data (in_data),
        .load_ctrl (in_ctrl),
        .valid     (skid_valid),
        .data      (skid_data),
        .ctrl      (skid_ctrl)
      );

      // Registered ready mirrors the next skid-empty state; held low in reset.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ready_q <= 1'b0;
        end else begin
          case (skid_op)
            SLOT_LOAD:  ready_q <= 1'b0;
            SLOT_CLEAR: ready_q <= 1'b1;
            default:    ready_q <= ~skid_valid;
          endcase
        end
      end

      assign in_ready = ready_q;
    end else begin : g_single
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;
      assign in_ready   = ~main_valid | (out_ready & ~stall);
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign count     = entry_count(main_valid, skid_valid);

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 64: width of the datapath payload (PC, operands, immediate, register indices).
REQ-002 Parameter CTRL_W, default 10: width of the control payload (branch, memread, memtoreg, memwrite, regwrite, alusrc, aluop, ...).
REQ-003 Parameter SKID, default 1: 1 gives a 2-entry skid buffer; 0 gives a single entry.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream stage presents a valid instruction.
REQ-007 in_ready  output  1  stage can accept this cycle.
REQ-008 in_data  input  DATA_W  upstream datapath payload.
REQ-009 in_ctrl  input  CTRL_W  upstream control payload.
REQ-010 out_valid  output  1  stage holds a valid instruction for downstream.
REQ-011 out_ready  input  1  downstream accepts this cycle.
REQ-012 out_data  output  DATA_W  registered datapath payload.
REQ-013 out_ctrl  output  CTRL_W  registered control payload; all-zero whenever out_valid=0.
REQ-014 stall  input  1  hazard-unit hold; acts as out_ready forced low.
REQ-015 flush  input  1  branch/exception squash of all held entries.
REQ-016 count  output  2  number of valid entries held (0..2; max 1 when SKID=0).

Function
REQ-017 Input transfer occurs when in_valid & in_ready; output transfer occurs when out_valid & out_ready & ~stall.
REQ-018 Latency from input transfer to out_valid is exactly 1 cycle when the stage is empty.
REQ-019 SKID=1: in_ready is registered and equals "skid entry empty", so it never depends combinationally on out_ready.
REQ-020 SKID=1: an input accepted while the main entry is held (no output transfer) goes to the skid entry, and count becomes 2.
REQ-021 SKID=1: on an output transfer with the skid entry full, the skid contents move to the main entry in the same edge; FIFO order is preserved.
REQ-022 SKID=1: with count=2, in_ready=0; simultaneous output transfer and in_valid does not accept the input that cycle.
REQ-023 SKID=0: in_ready = ~out_valid | (out_ready & ~stall); simultaneous input and output transfer replaces the entry, sustaining one transfer per cycle.
REQ-024 Sustained in_valid=1 and out_ready=1 with stall=0 yields one transfer per cycle in both modes.
REQ-025 Entries not written hold their data and ctrl unchanged; out_valid stays high under stall or while out_ready=0.
REQ-026 flush has top priority: on the next edge every entry becomes invalid, count=0, and ctrl is zeroed; any input offered in the flush cycle is discarded.
REQ-027 The flush cycle does not count as an output transfer, even if out_ready=1.
REQ-028 After flush, in_ready=1 on the following cycle.
REQ-029 stall and flush both high: flush wins.
REQ-030 Each field of in_ctrl is registered into its own bit position; no control bit is sourced from another field.
REQ-031 out_ctrl is gated to zero when out_valid=0, so an empty stage inserts a bubble with no side effects.
REQ-032 count = number of entries with valid set, updated on the same edge as those entries.

Reset
REQ-033 reset low asynchronously clears both valid bits, out_data, out_ctrl, skid data and skid ctrl to 0, and count to 0.
REQ-034 In reset, in_ready is 1 for SKID=0 and 0 for SKID=1; with SKID=1, in_ready rises to 1 on the first clk edge after reset deasserts.
REQ-035 Reset asserted mid-transfer discards all held entries, with no partial update.

Structure
REQ-036 A shared package pipe_pkg holds the default DATA_W, CTRL_W and SKID constants and a named index constant for each control bit (IDX_REGWRITE, IDX_MEMWRITE, ...).
REQ-037 One sub-module pipe_slot (valid + data + ctrl register with load/clear) is instantiated once per entry.

Verification
REQ-038 Reset: reset=0 with random inputs -> out_valid=0, out_ctrl=0, count=0; with SKID=1, in_ready=1 one edge after release.
REQ-039 Streaming: 8 inputs with in_data=0x1000..0x1007 and out_ready=1 -> outputs in order, one per cycle, 1-cycle latency.
REQ-040 Backpressure: with SKID=1, out_ready=0 while feeding 3 inputs -> 2 accepted, count=2, in_ready=0; then out_ready=1 -> 0x1000 then 0x1001 delivered, no loss or duplication.
REQ-041 Flush: count=2 and flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, count=0, and the offered input never appears at the output.
REQ-042 Stall: stall=1 for 3 cycles with out_ready=1 -> out_data stable and out_valid=1; release -> the entry transfers once.
REQ-043 Control integrity: in_ctrl with only IDX_MEMWRITE set -> out_ctrl has only IDX_MEMWRITE set, and the IDX_REGWRITE bit is 0.
